// File: rtl/m_div_pkg.sv
// Shared definitions for the EX-stage divide unit: bus width, ALUop codes
// for the RV32M multiply/divide group and the divider state encoding.
package m_div_pkg;

    localparam int REG_BUS_W = 32;

    localparam logic [5:0] ALU_MUL    = 6'b011000;
    localparam logic [5:0] ALU_MULH   = 6'b011001;
    localparam logic [5:0] ALU_MULHSU = 6'b011010;
    localparam logic [5:0] ALU_MULHU  = 6'b011011;
    localparam logic [5:0] ALU_DIV    = 6'b011100;
    localparam logic [5:0] ALU_DIVU   = 6'b011101;
    localparam logic [5:0] ALU_REM    = 6'b011110;
    localparam logic [5:0] ALU_REMU   = 6'b011111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic logic is_div_op(input logic [5:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) ||
               (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/m_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor if it fits.
module m_div_step
    import m_div_pkg::*;
#(
    parameter int XLEN = REG_BUS_W
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dvd_msb_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0] partial;
    logic [XLEN:0] trial;

    // rem < divisor holds between iterations, so partial < 2*divisor and the
    // top bit of the 33-bit difference is exactly the borrow.
    always_comb begin
        partial = {rem_i, dvd_msb_i};
        trial   = partial - {1'b0, divisor_i};
        q_bit_o = ~trial[XLEN];
        rem_o   = q_bit_o ? trial[XLEN-1:0] : partial[XLEN-1:0];
    end

endmodule

// File: rtl/m_div.sv
// Iterative radix-2 divider for DIV/DIVU/REM/REMU with a start/busy/done
// handshake and a flush that kills the in-flight operation.
module m_div
    import m_div_pkg::*;
#(
    parameter int XLEN  = REG_BUS_W,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [5:0]      ALUop,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;

    logic [XLEN-1:0] step_rem;
    logic            step_q_bit;

    logic            accept;
    logic            op_signed;
    logic            op_rem;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] special_res;

    m_div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[XLEN-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q_bit)
    );

    assign busy   = (state_q == CALC) || (state_q == FIX);
    assign done   = (state_q == DONE);
    assign result = result_q;

    always_comb begin
        op_signed   = (ALUop == ALU_DIV) || (ALUop == ALU_REM);
        op_rem      = (ALUop == ALU_REM) || (ALUop == ALU_REMU);
        a_neg       = op_signed & in1[XLEN-1];
        b_neg       = op_signed & in2[XLEN-1];
        a_mag       = a_neg ? -in1 : in1;
        b_mag       = b_neg ? -in2 : in2;
        div_zero    = (in2 == '0);
        overflow    = op_signed && (in1 == INT_MIN) && (in2 == '1);
        special_res = div_zero ? (op_rem ? in1 : '1) : (op_rem ? '0 : INT_MIN);
        accept      = start && !flush && !busy && is_div_op(ALUop);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    // Zero divisor and INT_MIN/-1 have fixed answers, skip the loop.
                    if (div_zero || overflow) begin
                        state_d  = DONE;
                        result_d = special_res;
                    end else begin
                        state_d   = CALC;
                        cnt_d     = CNT_W'(XLEN-1);
                        dvd_d     = a_mag;
                        rem_d     = '0;
                        dvs_d     = b_mag;
                        is_rem_d  = op_rem;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                    end
                end
            end
            CALC: begin
                dvd_d = {dvd_q[XLEN-2:0], step_q_bit};
                rem_d = step_rem;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d  = DONE;
                result_d = is_rem_q ? (neg_rem_q ? -rem_q : rem_q)
                                    : (neg_quo_q ? -dvd_q : dvd_q);
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

endmodule
